// File: rtl/uart_mem_bridge.sv
// UART command bridge: 8N1 byte commands drive data/address registers and a shared
// multi-channel memory port; read-style commands return multi-byte responses.
module uart_mem_bridge #(
    parameter int CLKS_PER_BIT = 105,
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 10,
    parameter int N_CH         = 3,
    parameter int RD_LAT       = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_rx,
    output logic                     o_tx,
    output logic [4:0]               o_led,
    output logic [ADDR_W-1:0]        o_mem_addr,
    output logic [DATA_W-1:0]        o_mem_wdata,
    output logic [N_CH-1:0]          o_mem_we,
    output logic [N_CH-1:0]          o_mem_re,
    input  logic [N_CH*DATA_W-1:0]   i_mem_rdata
);

    localparam int CNT_W      = $clog2(CLKS_PER_BIT);
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_BIT, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_CAPTURE} rd_state_t;
    typedef enum logic [3:0] {
        OP_DATA_RD = 4'd0, OP_DATA_LD = 4'd1, OP_ADDR_RD = 4'd2, OP_ADDR_LD = 4'd3,
        OP_CH_SEL  = 4'd4, OP_WRITE   = 4'd5, OP_READ    = 4'd6, OP_READ_TX = 4'd7,
        OP_STATUS  = 4'd8
    } opcode_t;

    // ---------------- RX ----------------
    logic                r_rx_s1, r_rx_s2, r_rx_s3;
    rx_state_t           r_rx_state, w_rx_next;
    logic [CNT_W-1:0]    r_rx_cnt;
    logic [2:0]          r_rx_bit;
    logic [7:0]          r_rx_shift;
    logic                w_rx_end, w_rx_valid, w_rx_ferr;

    always_comb begin
        w_rx_next  = r_rx_state;
        w_rx_end   = 1'b0;
        w_rx_valid = 1'b0;
        w_rx_ferr  = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (r_rx_s3 && !r_rx_s2) w_rx_next = RX_START;
            end
            RX_START: begin
                w_rx_end = (r_rx_cnt == HALF_END);
                if (w_rx_end) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                w_rx_end = (r_rx_cnt == BIT_END);
                if (w_rx_end && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            end
            RX_STOP: begin
                w_rx_end = (r_rx_cnt == BIT_END);
                if (w_rx_end) begin
                    w_rx_next  = RX_IDLE;
                    w_rx_valid = r_rx_s2;
                    w_rx_ferr  = !r_rx_s2;
                end
            end
            default: w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= i_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_s3    <= r_rx_s2;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= (r_rx_state == RX_IDLE || w_rx_end) ? '0 : r_rx_cnt + CNT_W'(1);
            if (r_rx_state == RX_IDLE) r_rx_bit <= '0;
            if (r_rx_state == RX_DATA && w_rx_end) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    // ---------------- Command decode ----------------
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_ch;
    logic [4:0]          r_led;
    logic [N_CH-1:0]     r_we, r_re;
    logic                r_err_ovf, r_err_frame, r_err_cmd;
    logic                r_wr_inc, r_rd_inc, r_rd_tx, r_tx_pend;
    rd_state_t           r_rd_state, w_rd_next;
    logic [1:0]          r_rd_cnt;

    logic [3:0]          w_op, w_arg;
    logic                w_tx_op, w_tx_busy, w_exec, w_drop, w_bad_cmd, w_ch_ok, w_rd_start;
    logic [N_CH-1:0]     w_ch_onehot;
    logic [DATA_W-1:0]   w_rdata_sel;
    logic [7:0]          w_status;

    assign w_op     = r_rx_shift[3:0];
    assign w_arg    = r_rx_shift[7:4];
    assign w_status = {r_err_ovf, r_err_frame, r_err_cmd, 1'b0, 2'b00, r_ch};

    tx_state_t           r_tx_state;
    assign w_tx_busy = (r_tx_state != TX_IDLE) || r_rd_tx || r_tx_pend;

    always_comb begin
        w_tx_op    = (w_op == OP_DATA_RD) || (w_op == OP_ADDR_RD) ||
                     (w_op == OP_READ_TX) || (w_op == OP_STATUS);
        // TX-producing commands are dropped whole while a response is pending
        w_exec     = w_rx_valid && !(w_tx_op && w_tx_busy);
        w_drop     = w_rx_valid && w_tx_op && w_tx_busy;
        w_ch_ok    = {28'd0, w_arg} < 32'(N_CH);
        w_bad_cmd  = w_rx_valid && ((w_op > 4'd8) || (w_op == OP_CH_SEL && !w_ch_ok));
        w_rd_start = w_exec && (w_op == OP_READ || w_op == OP_READ_TX);
        w_ch_onehot = '0;
        w_rdata_sel = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (r_ch == 2'(k)) begin
                w_ch_onehot[k] = 1'b1;
                w_rdata_sel    = i_mem_rdata[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        case (r_rd_state)
            RD_IDLE:    if (w_rd_start) w_rd_next = RD_WAIT;
            RD_WAIT:    if (r_rd_cnt == 2'(RD_LAT - 1)) w_rd_next = RD_CAPTURE;
            RD_CAPTURE: w_rd_next = RD_IDLE;
            default:    w_rd_next = RD_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data      <= '0;
            r_addr      <= '0;
            r_ch        <= '0;
            r_led       <= '0;
            r_we        <= '0;
            r_re        <= '0;
            r_err_ovf   <= 1'b0;
            r_err_frame <= 1'b0;
            r_err_cmd   <= 1'b0;
            r_wr_inc    <= 1'b0;
            r_rd_inc    <= 1'b0;
            r_rd_tx     <= 1'b0;
            r_tx_pend   <= 1'b0;
            r_rd_state  <= RD_IDLE;
            r_rd_cnt    <= '0;
        end else begin
            r_we       <= '0;
            r_re       <= '0;
            r_wr_inc   <= 1'b0;
            r_tx_pend  <= 1'b0;
            r_rd_state <= w_rd_next;
            r_rd_cnt   <= (r_rd_state == RD_WAIT) ? r_rd_cnt + 2'd1 : 2'd0;
            if (w_rx_valid) r_led <= r_rx_shift[4:0];
            if (w_exec) begin
                case (w_op)
                    OP_DATA_LD: r_data <= DATA_W'({r_data, w_arg});
                    OP_ADDR_LD: r_addr <= ADDR_W'({r_addr, w_arg});
                    OP_CH_SEL:  if (w_ch_ok) r_ch <= w_arg[1:0];
                    OP_WRITE: begin
                        r_we     <= w_ch_onehot;
                        r_wr_inc <= w_arg[0];
                    end
                    OP_READ, OP_READ_TX: begin
                        r_re     <= w_ch_onehot;
                        r_rd_inc <= w_arg[0];
                        r_rd_tx  <= (w_op == OP_READ_TX);
                    end
                    OP_STATUS: begin
                        r_err_ovf   <= 1'b0;
                        r_err_frame <= 1'b0;
                        r_err_cmd   <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (r_wr_inc) r_addr <= r_addr + ADDR_W'(1);
            if (r_rd_state == RD_CAPTURE) begin
                r_data    <= w_rdata_sel;
                r_tx_pend <= r_rd_tx;
                r_rd_tx   <= 1'b0;
                if (r_rd_inc) r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_rx_ferr) r_err_frame <= 1'b1;
            if (w_drop)    r_err_ovf   <= 1'b1;
            if (w_bad_cmd) r_err_cmd   <= 1'b1;
        end
    end

    // ---------------- TX ----------------
    tx_state_t           w_tx_next;
    logic [CNT_W-1:0]    r_tx_cnt;
    logic [2:0]          r_tx_bit;
    logic [7:0]          r_tx_byte;
    logic [23:0]         r_tx_buf;
    logic [1:0]          r_tx_left;
    logic                r_tx;
    logic                w_tx_end, w_tx_load;
    logic [31:0]         w_tx_payload;
    logic [1:0]          w_tx_nbytes;

    always_comb begin
        w_tx_load    = 1'b0;
        w_tx_payload = '0;
        w_tx_nbytes  = '0;
        if (r_tx_pend) begin
            w_tx_load    = 1'b1;
            w_tx_payload = 32'(r_data);
            w_tx_nbytes  = 2'(DATA_BYTES - 1);
        end else if (w_exec) begin
            case (w_op)
                OP_DATA_RD: begin
                    w_tx_load    = 1'b1;
                    w_tx_payload = 32'(r_data);
                    w_tx_nbytes  = 2'(DATA_BYTES - 1);
                end
                OP_ADDR_RD: begin
                    w_tx_load    = 1'b1;
                    w_tx_payload = 32'(r_addr);
                    w_tx_nbytes  = 2'(ADDR_BYTES - 1);
                end
                OP_STATUS: begin
                    w_tx_load    = 1'b1;
                    w_tx_payload = {24'd0, w_status};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tx_end  = (r_tx_cnt == BIT_END);
        w_tx_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE:  if (w_tx_load) w_tx_next = TX_START;
            TX_START: if (w_tx_end) w_tx_next = TX_BIT;
            TX_BIT:   if (w_tx_end && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            TX_STOP:  if (w_tx_end) w_tx_next = (r_tx_left != 2'd0) ? TX_START : TX_IDLE;
            default:  w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_byte  <= '0;
            r_tx_buf   <= '0;
            r_tx_left  <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= (r_tx_state == TX_IDLE || w_tx_end) ? '0 : r_tx_cnt + CNT_W'(1);
            case (r_tx_state)
                TX_IDLE: if (w_tx_load) begin
                    r_tx_byte <= w_tx_payload[7:0];
                    r_tx_buf  <= w_tx_payload[31:8];
                    r_tx_left <= w_tx_nbytes;
                    r_tx      <= 1'b0;
                end
                TX_START: if (w_tx_end) begin
                    r_tx     <= r_tx_byte[0];
                    r_tx_bit <= '0;
                end
                TX_BIT: if (w_tx_end) begin
                    if (r_tx_bit == 3'd7) begin
                        r_tx <= 1'b1;
                    end else begin
                        r_tx      <= r_tx_byte[1];
                        r_tx_byte <= {1'b0, r_tx_byte[7:1]};
                        r_tx_bit  <= r_tx_bit + 3'd1;
                    end
                end
                TX_STOP: if (w_tx_end && r_tx_left != 2'd0) begin
                    r_tx_left <= r_tx_left - 2'd1;
                    r_tx_byte <= r_tx_buf[7:0];
                    r_tx_buf  <= {8'd0, r_tx_buf[23:8]};
                    r_tx      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_tx        = r_tx;
    assign o_led       = r_led;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_data;
    assign o_mem_we    = r_we;
    assign o_mem_re    = r_re;

endmodule
